// File: rtl/bfly2_pipe.sv
// Radix-2 complex butterfly, 3-stage pipeline: sum path and twiddled difference path.
// Optional BFLY2_PIPE_SAT_EN: clamp out-of-range results instead of wrapping.
module bfly2_pipe #(
  parameter int SIG    = 1,
  parameter int INT    = 3,
  parameter int FLT    = 6,
  parameter int WIDTH  = SIG + INT + FLT,
  parameter int TW_FLT = 7,
  parameter int TWW    = TW_FLT + 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic signed [WIDTH-1:0] din1_re,
  input  logic signed [WIDTH-1:0] din1_im,
  input  logic signed [WIDTH-1:0] din2_re,
  input  logic signed [WIDTH-1:0] din2_im,
  input  logic signed [TWW-1:0]   tw_re,
  input  logic signed [TWW-1:0]   tw_im,
  input  logic                    scale,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic signed [WIDTH:0]   dout1_re,
  output logic signed [WIDTH:0]   dout1_im,
  output logic signed [WIDTH:0]   dout2_re,
  output logic signed [WIDTH:0]   dout2_im,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    ovf
);
  localparam int DW = WIDTH + 1;
  localparam int PW = DW + TWW;
  localparam int RW = PW + 2;
  localparam logic signed [RW-1:0] RND_LO = RW'(1) <<< (TW_FLT - 1);
  localparam logic signed [RW-1:0] RND_HI = RW'(1) <<< TW_FLT;

  function automatic logic signed [DW-1:0] sx_in(input logic signed [WIDTH-1:0] x);
    return {x[WIDTH-1], x};
  endfunction
  function automatic logic signed [PW-1:0] sx_d(input logic signed [DW-1:0] x);
    return {{(PW-DW){x[DW-1]}}, x};
  endfunction
  function automatic logic signed [PW-1:0] sx_t(input logic signed [TWW-1:0] x);
    return {{(PW-TWW){x[TWW-1]}}, x};
  endfunction
  function automatic logic signed [RW-1:0] sx_p(input logic signed [PW-1:0] x);
    return {{(RW-PW){x[PW-1]}}, x};
  endfunction
  // Out of range when the bits above the output sign bit are not all copies of it.
  function automatic logic oor(input logic [RW-1:0] q);
    return !((&q[RW-1:DW-1]) || !(|q[RW-1:DW-1]));
  endfunction
  function automatic logic [DW-1:0] fit(input logic [RW-1:0] q);
`ifdef BFLY2_PIPE_SAT_EN
    if (oor(q)) return q[RW-1] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
`endif
    return q[DW-1:0];
  endfunction

  // Handshake: a transfer happens on a rising edge where valid and ready are both 1;
  // a stalled output (out_valid & ~out_ready) freezes every stage and drops in_ready.
  logic w_stall;
  assign w_stall  = out_valid & ~out_ready;
  assign in_ready = ~w_stall;

  // S1: add/sub at full precision
  logic signed [DW-1:0]  r_sum_re, r_sum_im, r_diff_re, r_diff_im;
  logic signed [TWW-1:0] r_tw_re, r_tw_im;
  logic                  r_scale1, r_v1;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_v1 <= 1'b0; r_scale1 <= 1'b0;
      r_sum_re <= '0; r_sum_im <= '0; r_diff_re <= '0; r_diff_im <= '0;
      r_tw_re <= '0; r_tw_im <= '0;
    end else if (!w_stall) begin
      r_v1      <= in_valid;
      r_scale1  <= scale;
      r_sum_re  <= sx_in(din1_re) + sx_in(din2_re);
      r_sum_im  <= sx_in(din1_im) + sx_in(din2_im);
      r_diff_re <= sx_in(din1_re) - sx_in(din2_re);
      r_diff_im <= sx_in(din1_im) - sx_in(din2_im);
      r_tw_re   <= tw_re;
      r_tw_im   <= tw_im;
    end
  end

  // S2: four partial products
  logic signed [PW-1:0] r_rr, r_ii, r_ri, r_ir;
  logic signed [DW-1:0] r_sum2_re, r_sum2_im;
  logic                 r_scale2, r_v2;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_v2 <= 1'b0; r_scale2 <= 1'b0;
      r_rr <= '0; r_ii <= '0; r_ri <= '0; r_ir <= '0;
      r_sum2_re <= '0; r_sum2_im <= '0;
    end else if (!w_stall) begin
      r_v2      <= r_v1;
      r_scale2  <= r_scale1;
      r_rr      <= sx_d(r_diff_re) * sx_t(r_tw_re);
      r_ii      <= sx_d(r_diff_im) * sx_t(r_tw_im);
      r_ri      <= sx_d(r_diff_re) * sx_t(r_tw_im);
      r_ir      <= sx_d(r_diff_im) * sx_t(r_tw_re);
      r_sum2_re <= r_sum_re;
      r_sum2_im <= r_sum_im;
    end
  end

  // S3: combine, round half up, range-fit
  logic signed [RW-1:0] w_rnd, w_pr_re, w_pr_im, w_q_re, w_q_im;
  logic [DW:0]          w_inc_re, w_inc_im;
  logic [DW-1:0]        w_d1_re, w_d1_im;
  logic                 w_oor;
  assign w_rnd    = r_scale2 ? RND_HI : RND_LO;
  assign w_pr_re  = sx_p(r_rr) - sx_p(r_ii) + w_rnd;
  assign w_pr_im  = sx_p(r_ri) + sx_p(r_ir) + w_rnd;
  assign w_q_re   = r_scale2 ? (w_pr_re >>> (TW_FLT + 1)) : (w_pr_re >>> TW_FLT);
  assign w_q_im   = r_scale2 ? (w_pr_im >>> (TW_FLT + 1)) : (w_pr_im >>> TW_FLT);
  // The halved sum always fits, so only the twiddled path can overflow.
  assign w_inc_re = {r_sum2_re[DW-1], r_sum2_re} + {{DW{1'b0}}, 1'b1};
  assign w_inc_im = {r_sum2_im[DW-1], r_sum2_im} + {{DW{1'b0}}, 1'b1};
  assign w_d1_re  = r_scale2 ? w_inc_re[DW:1] : r_sum2_re;
  assign w_d1_im  = r_scale2 ? w_inc_im[DW:1] : r_sum2_im;
  assign w_oor    = oor(w_q_re) | oor(w_q_im);

  logic                 r_v3, r_ovf;
  logic signed [DW-1:0] r_d1_re, r_d1_im, r_d2_re, r_d2_im;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_v3 <= 1'b0;
      r_d1_re <= '0; r_d1_im <= '0; r_d2_re <= '0; r_d2_im <= '0;
    end else if (!w_stall) begin
      r_v3    <= r_v2;
      r_d1_re <= w_d1_re;
      r_d1_im <= w_d1_im;
      r_d2_re <= fit(w_q_re);
      r_d2_im <= fit(w_q_im);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_ovf <= 1'b0;
    else if (r_v2 && w_oor) r_ovf <= 1'b1;
  end

  assign out_valid = r_v3;
  assign dout1_re  = r_d1_re;
  assign dout1_im  = r_d1_im;
  assign dout2_re  = r_d2_re;
  assign dout2_im  = r_d2_im;
  assign ovf       = r_ovf;
endmodule

// File: tb/tb_bfly2_pipe.sv
// Self-checking bench for bfly2_pipe (WIDTH=10, TW_FLT=7): directed vectors plus scoreboarded random traffic.
module tb_bfly2_pipe;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst, scale, in_valid, in_ready, out_valid, out_ready, ovf;
  logic signed [9:0] din1_re, din1_im, din2_re, din2_im;
  logic signed [8:0] tw_re, tw_im;
  logic signed [10:0] dout1_re, dout1_im, dout2_re, dout2_im;

  bfly2_pipe dut (
    .clk(clk), .rst(rst),
    .din1_re(din1_re), .din1_im(din1_im), .din2_re(din2_re), .din2_im(din2_im),
    .tw_re(tw_re), .tw_im(tw_im), .scale(scale),
    .in_valid(in_valid), .in_ready(in_ready),
    .dout1_re(dout1_re), .dout1_im(dout1_im), .dout2_re(dout2_re), .dout2_im(dout2_im),
    .out_valid(out_valid), .out_ready(out_ready), .ovf(ovf)
  );

  int total = 0;
  int bad   = 0;
  logic [44:0] exp_q[$];
  logic [44:0] cur_exp;
  logic        prev_stall = 1'b0;
  logic [43:0] prev_obs;

  task automatic check_val(input string tag, input logic signed [63:0] obs,
                           input logic signed [63:0] exp_v);
    total++;
    if (obs !== exp_v) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  function automatic logic [11:0] fit11(input int q);
    logic [31:0] u;
    u = q;
    if (q > 1023 || q < -1024) begin
`ifdef BFLY2_PIPE_SAT_EN
      return {1'b1, (q > 0) ? 11'h3FF : 11'h400};
`else
      return {1'b1, u[10:0]};
`endif
    end
    return {1'b0, u[10:0]};
  endfunction

  // Reference: {ovf, dout1_re, dout1_im, dout2_re, dout2_im}
  function automatic logic [44:0] model(input int a1r, a1i, a2r, a2i, twr, twi, sc);
    int sr, si, dr, di, pr, pi, k, q1r, q1i, q2r, q2i;
    logic [11:0] f1r, f1i, f2r, f2i;
    sr = a1r + a2r; si = a1i + a2i;
    dr = a1r - a2r; di = a1i - a2i;
    pr = dr * twr - di * twi;
    pi = dr * twi + di * twr;
    k  = 7 + sc;
    q2r = (pr + (1 << (k - 1))) >>> k;
    q2i = (pi + (1 << (k - 1))) >>> k;
    q1r = (sc != 0) ? ((sr + 1) >>> 1) : sr;
    q1i = (sc != 0) ? ((si + 1) >>> 1) : si;
    f1r = fit11(q1r); f1i = fit11(q1i); f2r = fit11(q2r); f2i = fit11(q2i);
    return {f2r[11] | f2i[11], f1r[10:0], f1i[10:0], f2r[10:0], f2i[10:0]};
  endfunction

  task automatic set_in(input int a1r, a1i, a2r, a2i, twr, twi, sc, input logic v);
    din1_re = 10'(a1r); din1_im = 10'(a1i);
    din2_re = 10'(a2r); din2_im = 10'(a2i);
    tw_re = 9'(twr); tw_im = 9'(twi);
    scale = sc[0];
    in_valid = v;
    cur_exp = model(a1r, a1i, a2r, a2i, twr, twi, sc);
  endtask

  task automatic set_rand(input logic v);
    int a1r, a1i, a2r, a2i, twr, twi;
    a1r = $urandom_range(0, 510); a1r -= 255;
    a1i = $urandom_range(0, 510); a1i -= 255;
    a2r = $urandom_range(0, 510); a2r -= 255;
    a2i = $urandom_range(0, 510); a2i -= 255;
    twr = $urandom_range(0, 256); twr -= 128;
    twi = $urandom_range(0, 256); twi -= 128;
    set_in(a1r, a1i, a2r, a2i, twr, twi, int'($urandom_range(0, 1)), v);
  endtask

  // One clock: handshakes observed between edges, then advance to the next falling edge.
  task automatic cyc();
    logic [43:0] obs;
    logic [44:0] e;
    #1;
    obs = {dout1_re, dout1_im, dout2_re, dout2_im};
    if (!rst) begin
      if (prev_stall) check_val("frozen", obs, prev_obs);
      if (in_valid && in_ready) exp_q.push_back(cur_exp);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check_val("spurious_out", out_valid, 0);
        else begin
          e = exp_q.pop_front();
          check_val("data", obs, e[43:0]);
          if (e[44]) check_val("ovf_on_sample", ovf, 1);
        end
      end
      prev_stall = out_valid && !out_ready;
    end else prev_stall = 1'b0;
    prev_obs = obs;
    @(posedge clk);
    if (rst) exp_q.delete();
    @(negedge clk);
  endtask

  task automatic drain();
    int n;
    out_ready = 1'b1;
    in_valid  = 1'b0;
    n = 0;
    while (exp_q.size() > 0 && n < 50) begin
      cyc();
      n++;
    end
    check_val("drain_empty", exp_q.size(), 0);
  endtask

  task automatic shot(input string tag, input int a1r, a1i, a2r, a2i, twr, twi, sc,
                      input int e1r, e1i, e2r, e2i, input logic e_ovf);
    int n;
    out_ready = 1'b1;
    set_in(a1r, a1i, a2r, a2i, twr, twi, sc, 1'b1);
    cyc();
    in_valid = 1'b0;
    n = 1;
    while (!out_valid && n < 10) begin
      cyc();
      n++;
    end
    check_val({tag, "_latency"}, n, 3);
    check_val({tag, "_d1re"}, dout1_re, e1r);
    check_val({tag, "_d1im"}, dout1_im, e1i);
    check_val({tag, "_d2re"}, dout2_re, e2r);
    check_val({tag, "_d2im"}, dout2_im, e2i);
    check_val({tag, "_ovf"}, ovf, e_ovf);
    cyc();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int ovf_d2im;
    rst = 1'b1;
    out_ready = 1'b1;
    set_in(0, 0, 0, 0, 0, 0, 0, 1'b0);
    cyc(); cyc();
    rst = 1'b0;
    check_val("rst_out_valid", out_valid, 0);
    check_val("rst_ovf", ovf, 0);
    check_val("rst_dout", {dout1_re, dout1_im, dout2_re, dout2_im}, 0);
    check_val("rst_in_ready", in_ready, 1);

    shot("identity", 100, 0, 50, 0, 128, 0, 0, 150, 0, 50, 0, 1'b0);
    shot("rot_negj", 60, 30, 10, 10, 0, -128, 0, 70, 40, 20, -50, 1'b0);
    shot("scale", 101, 0, 0, 0, 128, 0, 1, 51, 0, 51, 0, 1'b0);

    // Backpressure: three samples in flight, output blocked for four cycles
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      set_rand(1'b1);
      cyc();
    end
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check_val("bp_in_ready", in_ready, 0);
      check_val("bp_out_valid", out_valid, 1);
      check_val("bp_inflight", exp_q.size(), 3);
      set_rand(1'b1);
      cyc();
    end
    in_valid = 1'b0;
    drain();

    // Random traffic with random backpressure and bubbles
    for (int i = 0; i < 300; i++) begin
      set_rand($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      cyc();
    end
    drain();
    check_val("no_ovf_in_range", ovf, 0);

`ifdef BFLY2_PIPE_SAT_EN
    ovf_d2im = 1023;
`else
    ovf_d2im = -2;
`endif
    shot("overflow", 511, 511, -512, -512, 128, 128, 0, -1, -1, 0, ovf_d2im, 1'b1);

    // Reset in the middle of continuous traffic
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      set_in(511, 511, -512, -512, 128, 128, 0, 1'b1);
      cyc();
    end
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    check_val("midrst_out_valid", out_valid, 0);
    check_val("midrst_ovf", ovf, 0);
    check_val("midrst_in_ready", in_ready, 1);
    for (int i = 0; i < 10; i++) begin
      set_rand(1'b1);
      cyc();
    end
    drain();
    check_val("post_rst_ovf", ovf, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
